mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative multiply/divide unit for the MIPS datapath, executing MULT, MULTU, DIV and DIVU. Sits directly upstream of the HI and LO `Register` instances: its `hi`/`lo` outputs drive their `in` ports, and `done` drives their `load`. Operands come from the register-file read ports. The pipeline controller stalls on `busy`.

## Interface
- `WIDTH`, 32: operand and result width.

- `clk`  in  1: rising-edge clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `start`  in  1: request a new operation; sampled only while idle.
- `op`  in  2: operation select; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  WIDTH: multiplicand or dividend.
- `b`  in  WIDTH: multiplier or divisor.
- `busy`  out  1: operation in progress; high from the edge after `start` through the last iteration.
- `done`  out  1: one-cycle pulse when `hi`/`lo` hold a new result.
- `hi`  out  WIDTH: upper product half, or remainder.
- `lo`  out  WIDTH: lower product half, or quotient.

## Operation
- FSM states: IDLE, RUN, FIX.
  - IDLE→RUN on `start`. At that edge, latch `op`, |a|, |b| (two's-complement magnitude for signed ops) and the operand signs.
  - RUN executes one radix-2 step per cycle, counted by a 5-bit iteration counter 0..31. Counter value 31 → FIX.
  - FIX → IDLE unconditionally. At this edge, write `hi`/`lo` and pulse `done`.
- Multiply:
  - Shift-add on a 2·WIDTH accumulator.
  - Signed: negate the 64-bit product if the operand signs differ.
- Divide:
  - Restoring shift-subtract.
  - Signed: negate the quotient if the signs differ. The remainder takes the sign of the dividend.
- Boundary rules:
  - Divide by zero (DIV or DIVU): `lo`=FFFFFFFF, `hi`=`a` as latched, with no sign fixup.
  - DIV 0x80000000 / 0xFFFFFFFF: `lo`=80000000, `hi`=00000000. This is the natural wrap; no special case is needed.
  - 0x80000000 magnitude is handled as unsigned 2^31. The internal width must not truncate it.
- `a`, `b` and `op` may change freely after the start edge. Only latched copies are used.
- `start` while `busy` or in FIX is ignored; no queueing.
- `hi`/`lo` hold their value between operations and change only at the FIX edge.

## Timing
- Reset (async, any time, including mid-operation):
  - State → IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0.
  - The operation in flight is abandoned, with no `done`.
- Start sampled at edge E0. `busy`=1 after E0.
- RUN occupies edges E1..E32.
- FIX executes at E33. After E33: `busy`=0, `done`=1, `hi`/`lo` valid.
- After E34: `done`=0.
- Fixed latency for every op and operand value: `done` rises 33 cycles after the start edge.
- Back-to-back operation: `start` held high during the `done` cycle is accepted at E34, because the state is IDLE. `busy` is not high in the `done` cycle.
- The HI/LO `Register`s capture on the edge that ends the `done` cycle (E34), so results are architecturally visible one cycle after `done`.

## Structure
- Shared header `mips_defs.vh` holds:
  - `op` encodings: `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`.
  - FSM state encodings.
  - `WIDTH` default.
  - The ALU and decoder also use these.
- One sub-module, `md_step`, is natural. It is combinational: one shift-add or shift-subtract step on {accumulator, operand}, selected by a mul/div bit. `mult_div_unit` keeps the FSM, counter, sign logic and output registers.
- Expected size: ~200 lines total.

## Test plan
- MULTU FFFFFFFF × FFFFFFFF → after 33 cycles: `done`=1 for one cycle, `hi`=FFFFFFFE, `lo`=00000001. `busy` was high for cycles 1–32.
- MULT FFFFFFFD (−3) × 00000005 → `hi`=FFFFFFFF, `lo`=FFFFFFF1.
- DIV FFFFFFF9 (−7) ÷ 00000002 → `lo`=FFFFFFFD, `hi`=FFFFFFFF.
- DIVU DEADBEEF ÷ 00000010 → `lo`=0DEADBEE, `hi`=0000000F.
- Boundary cases:
  - DIVU 00001234 ÷ 0 → `lo`=FFFFFFFF, `hi`=00001234.
  - DIV 80000000 ÷ FFFFFFFF → `lo`=80000000, `hi`=0.
- Robustness:
  - `start` pulsed again at cycle 5 with new operands → ignored, and the first result is unchanged.
  - `start` held high through `done` → the second op is accepted at E34.
  - `rst` asserted mid-RUN at cycle 10 → `busy`/`hi`/`lo` go to 0 immediately, and no `done` ever appears for that op.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and the default datapath width.
package mult_div_unit_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } md_state_t;

endpackage

// File: rtl/mult_div_unit_md_step.sv
// One radix-2 iteration: shift-add for multiply (acc:q shifts right) or
// restoring shift-subtract for divide (acc:q shifts left).
module md_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH:0]   acc_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        sum      = acc + (q[0] ? {1'b0, operand} : '0);
        shifted  = {acc[WIDTH-1:0], q[WIDTH-1]};
        diff     = {1'b0, shifted} - {2'b00, operand};
        acc_next = {1'b0, sum[WIDTH:1]};
        q_next   = {sum[0], q[WIDTH-1:1]};
        if (is_div) begin
            // A non-negative trial difference means the divisor fits: keep it.
            if (!diff[WIDTH+1]) begin
                acc_next = diff[WIDTH:0];
                q_next   = {q[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = shifted;
                q_next   = {q[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit feeding the HI/LO registers; fixed
// 33-cycle latency from the start edge to the done pulse.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_t          state, next_state;
    logic [4:0]         count;
    logic [1:0]         op_r;
    logic               neg_a, neg_b;
    logic [WIDTH:0]     acc, acc_next;
    logic [WIDTH-1:0]   q, q_next, operand;
    logic               signed_in, signed_op;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    md_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (op_r[1]),
        .acc      (acc),
        .q        (q),
        .operand  (operand),
        .acc_next (acc_next),
        .q_next   (q_next)
    );

    assign signed_in = (op == MD_MULT) || (op == MD_DIV);
    assign signed_op = (op_r == MD_MULT) || (op_r == MD_DIV);
    assign mag_a     = (signed_in && a[WIDTH-1]) ? -a : a;
    assign mag_b     = (signed_in && b[WIDTH-1]) ? -b : b;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start) next_state = ST_RUN;
            ST_RUN:  if (count == 5'd31) next_state = ST_FIX;
            ST_FIX:  next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Sign fixup. A zero divisor leaves acc = |a| and q = all ones, so the
    // remainder fixup alone restores the raw dividend into hi.
    always_comb begin
        prod     = {acc[WIDTH-1:0], q};
        prod_fix = (signed_op && (neg_a ^ neg_b)) ? -prod : prod;
        rem_fix  = (signed_op && neg_a) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        quo_fix  = q;
        if (operand != '0 && signed_op && (neg_a ^ neg_b))
            quo_fix = -q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            op_r    <= '0;
            neg_a   <= 1'b0;
            neg_b   <= 1'b0;
            acc     <= '0;
            q       <= '0;
            operand <= '0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            done <= (state == ST_FIX);
            case (state)
                ST_IDLE: if (start) begin
                    op_r    <= op;
                    neg_a   <= signed_in && a[WIDTH-1];
                    neg_b   <= signed_in && b[WIDTH-1];
                    acc     <= '0;
                    q       <= op[1] ? mag_a : mag_b;
                    operand <= op[1] ? mag_b : mag_a;
                    count   <= '0;
                end
                ST_RUN: begin
                    acc   <= acc_next;
                    q     <= q_next;
                    count <= count + 5'd1;
                end
                ST_FIX: begin
                    if (op_r[1]) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: arithmetic results,
// latency, boundary divides, ignored starts, back-to-back and async reset.
module tb_mult_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one start pulse; returns just after the accepting edge (E0).
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges until done is seen (bounded); also counts busy gaps in edges 1..32.
    task automatic waitDone(output int n, output int gaps);
        n    = 0;
        gaps = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n <= 32 && !busy) gaps++;
        end while (!done && n < 100);
    endtask

    task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
        int n;
        int gaps;
        applyStimulus(o, x, y);
        checkOutput({tag, " busy_after_start"}, 64'(busy), 64'(1));
        waitDone(n, gaps);
        checkOutput({tag, " latency"}, 64'(n), 64'(33));
        checkOutput({tag, " busy_gaps"}, 64'(gaps), 64'(0));
        checkOutput({tag, " hi"}, 64'(hi), 64'(eh));
        checkOutput({tag, " lo"}, 64'(lo), 64'(el));
        checkOutput({tag, " busy_in_done"}, 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        checkOutput({tag, " done_pulse_end"}, 64'(done), 64'(0));
    endtask

    initial begin
        int n;
        int gaps;
        int done_seen;

        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        #2;
        checkOutput("reset busy", 64'(busy), 64'(0));
        checkOutput("reset done", 64'(done), 64'(0));
        checkOutput("reset hi", 64'(hi), 64'(0));
        checkOutput("reset lo", 64'(lo), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        runOp("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        runOp("mult_neg",  2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1);
        runOp("mult_min",  2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        runOp("div_neg",   2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        runOp("divu",      2'b11, 32'hDEADBEEF, 32'h00000010, 32'h0000000F, 32'h0DEADBEE);
        runOp("divu_zero", 2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF);
        runOp("div_zero",  2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF);
        runOp("div_wrap",  2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

        // Second start at cycle 5 must be ignored.
        applyStimulus(2'b01, 32'd3, 32'd4);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        op    = 2'b11;
        a     = 32'd100;
        b     = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(n, gaps);
        checkOutput("ignore latency", 64'(n), 64'(28));
        checkOutput("ignore hi", 64'(hi), 64'(0));
        checkOutput("ignore lo", 64'(lo), 64'(12));
        @(posedge clk);
        #1;
        checkOutput("ignore done_end", 64'(done), 64'(0));

        // Start held high throughout: second op accepted at E34.
        @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        a     = 32'd2;
        b     = 32'd3;
        @(posedge clk);
        #1;
        op = 2'b11;
        a  = 32'd100;
        b  = 32'd7;
        waitDone(n, gaps);
        checkOutput("b2b first latency", 64'(n), 64'(33));
        checkOutput("b2b first lo", 64'(lo), 64'(6));
        checkOutput("b2b first hi", 64'(hi), 64'(0));
        checkOutput("b2b busy_in_done", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("b2b accepted busy", 64'(busy), 64'(1));
        checkOutput("b2b done_end", 64'(done), 64'(0));
        waitDone(n, gaps);
        checkOutput("b2b second latency", 64'(n), 64'(33));
        checkOutput("b2b second lo", 64'(lo), 64'(14));
        checkOutput("b2b second hi", 64'(hi), 64'(2));

        // Async reset in the middle of RUN abandons the operation.
        applyStimulus(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst busy", 64'(busy), 64'(0));
        checkOutput("midrst hi", 64'(hi), 64'(0));
        checkOutput("midrst lo", 64'(lo), 64'(0));
        checkOutput("midrst done", 64'(done), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        checkOutput("midrst no_done", 64'(done_seen), 64'(0));
        checkOutput("midrst idle", 64'(busy), 64'(0));

        runOp("after_rst", 2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
